find_extreme_seq: RTL and testbench

// Parametrised sequential min/max reducer over N packed W-bit elements; the

---
 rtl/find_extreme_seq.sv | 116 +++++++++++
 tb/tb_find_extreme_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/find_extreme_seq.sv
// Sequential min/max reducer over N packed W-bit elements, LANES elements per clock,
// with signed/unsigned compare and argmin/argmax index output.
module find_extreme_seq #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int LANES = 1,
    localparam int IDXW = ($clog2(N) > 0) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode_max,
    input  logic            is_signed,
    input  logic [N*W-1:0]  numbers,
    output logic            busy,
    output logic            done,
    output logic [W-1:0]    result,
    output logic [IDXW-1:0] index
);

    localparam int G  = (N + LANES - 1) / LANES;
    localparam int GW = ($clog2(G) > 0) ? $clog2(G) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t          state, state_next;
    logic [W-1:0]    elems [N];
    logic            cap_max, cap_signed;
    logic [GW-1:0]   group;
    logic [W-1:0]    acc_val;
    logic [IDXW-1:0] acc_idx;
    logic [W-1:0]    best_val;
    logic [IDXW-1:0] best_idx;
    logic            capture, last_group;

    assign capture    = (state != SCAN) && start;
    assign last_group = (group == GW'(G - 1));
    assign busy       = (state == SCAN);
    assign done       = (state == DONE);

    function automatic logic beats(input logic [W-1:0] cand, input logic [W-1:0] cur,
                                   input logic want_max, input logic use_signed);
        logic lt, gt;
        if (use_signed) begin
            lt = $signed(cand) < $signed(cur);
            gt = $signed(cand) > $signed(cur);
        end else begin
            lt = cand < cur;
            gt = cand > cur;
        end
        return want_max ? gt : lt;
    endfunction

    // Lane tree: ascending lane order plus a strict compare keeps the lowest index on ties.
    always_comb begin
        int   idx;
        logic have;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
        best_val = acc_val;
        best_idx = acc_idx;
        have     = (group != '0);
        // NOTE: blocking assignments here model a chain of compares evaluated in order within one cycle.
        for (int l = 0; l < LANES; l++) begin
            idx = int'(group) * LANES + l;
            if (idx < N) begin
                if (!have || beats(elems[IDXW'(idx)], best_val, cap_max, cap_signed)) begin
                    best_val = elems[IDXW'(idx)];
                    best_idx = IDXW'(idx);
                    have     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last_group) state_next = DONE;
            DONE:    state_next = start ? SCAN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            group      <= '0;
            acc_val    <= '0;
            acc_idx    <= '0;
            cap_max    <= 1'b0;
            cap_signed <= 1'b0;
            result     <= '0;
            index      <= '0;
            // NOTE: the element copy is a small register bank, not a RAM, so clearing it on reset is cheap and intended.
            for (int i = 0; i < N; i++) elems[i] <= '0;
        end else begin
            state <= state_next;
            if (capture) begin
                for (int i = 0; i < N; i++) elems[i] <= numbers[i*W +: W];
                cap_max    <= mode_max;
                cap_signed <= is_signed;
                group      <= '0;
            end else if (state == SCAN) begin
                acc_val <= best_val;
                acc_idx <= best_idx;
                group   <= group + GW'(1);
                if (last_group) begin
                    result <= best_val;
                    index  <= best_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_find_extreme_seq.sv
// Self-checking bench: one instance with LANES=1 (G=8) and one with LANES=3 (G=3),
// table vectors, hand-written corner sequences and randomized jobs against a model.
module tb_find_extreme_seq;

    localparam int N = 8;
    localparam int W = 16;
    localparam int IDXW = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic            start_a, mode_a, sgn_a, busy_a, done_a;
    logic [N*W-1:0]  nums_a;
    logic [W-1:0]    result_a;
    logic [IDXW-1:0] index_a;
    logic            start_b, mode_b, sgn_b, busy_b, done_b;
    logic [N*W-1:0]  nums_b;
    logic [W-1:0]    result_b;
    logic [IDXW-1:0] index_b;

    find_extreme_seq #(.N(N), .W(W), .LANES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode_max(mode_a), .is_signed(sgn_a),
        .numbers(nums_a), .busy(busy_a), .done(done_a), .result(result_a), .index(index_a));

    find_extreme_seq #(.N(N), .W(W), .LANES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode_max(mode_b), .is_signed(sgn_b),
        .numbers(nums_b), .busy(busy_b), .done(done_b), .result(result_b), .index(index_b));

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference: linear scan over integer values, first strict winner kept.
    function automatic void model(input logic [N*W-1:0] nums, input logic mm, input logic sg,
                                  output logic [W-1:0] res, output int idx);
        longint best, v;
        best = 0;
        idx  = 0;
        for (int i = 0; i < N; i++) begin
            v = sg ? longint'($signed(nums[i*W +: W])) : longint'(nums[i*W +: W]);
            if (i == 0 || (mm ? (v > best) : (v < best))) begin
                best = v;
                idx  = i;
            end
        end
        res = nums[idx*W +: W];
    endfunction

    // One job on instance a (sel=0) or b (sel=1): latency, result, index, one-cycle done.
    task automatic run_job(input bit sel, input logic [N*W-1:0] nums, input logic mm, input logic sg,
                           input logic [W-1:0] exp_res, input int exp_idx, input string tag);
        int lat;
        @(negedge clk);
        if (sel) begin start_b = 1'b1; nums_b = nums; mode_b = mm; sgn_b = sg; end
        else     begin start_a = 1'b1; nums_a = nums; mode_a = mm; sgn_a = sg; end
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, " busy"}, sel ? busy_b : busy_a, 1'b1);
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (sel ? done_b : done_a) begin
                lat = k;
                break;
            end
        end
        check({tag, " latency"}, lat, sel ? 3 : 8);
        check({tag, " result"}, sel ? result_b : result_a, exp_res);
        check({tag, " index"}, sel ? index_b : index_a, exp_idx);
        @(negedge clk);
        check({tag, " done width"}, sel ? done_b : done_a, 1'b0);
    endtask

    typedef struct {
        logic [N*W-1:0] nums;
        logic           mm;
        logic           sg;
        logic [W-1:0]   exp_res;
        int             exp_idx;
    } vec_t;

    localparam logic [N*W-1:0] DATA = {16'h0004, 16'h0007, 16'h0009, 16'h0100,
                                       16'h0003, 16'hFFFF, 16'h0003, 16'h0005};

    vec_t vecs[8];

    initial begin
        logic [W-1:0]   r;
        int             ix, cnt, first_k, prev_k, gaps_ok;
        logic [N*W-1:0] rn;
        logic           rm, rs;

        vecs[0] = '{DATA, 1'b0, 1'b0, 16'h0003, 1};
        vecs[1] = '{DATA, 1'b1, 1'b1, 16'h0100, 4};
        vecs[2] = '{DATA, 1'b0, 1'b1, 16'hFFFF, 2};
        vecs[3] = '{DATA, 1'b1, 1'b0, 16'hFFFF, 2};
        vecs[4] = '{{16'hFFFF, 16'h0007, 16'h0006, 16'h0005, 16'h0004, 16'h0003, 16'h0002, 16'h0001},
                    1'b1, 1'b0, 16'hFFFF, 7};
        vecs[5] = '{{16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008, 16'h0009},
                    1'b0, 1'b0, 16'h0002, 7};
        vecs[6] = '{{N{16'h8000}}, 1'b0, 1'b1, 16'h8000, 0};
        vecs[7] = '{{16'hC000, 16'hA000, 16'h9000, 16'hFFFF, 16'hFFFF, 16'h8001, 16'hFFFE, 16'h8000},
                    1'b1, 1'b1, 16'hFFFF, 3};

        start_a = 1'b1; mode_a = 1'b0; sgn_a = 1'b0; nums_a = DATA;
        start_b = 1'b1; mode_b = 1'b0; sgn_b = 1'b0; nums_b = DATA;
        rst_n = 1'b0;

        // Reset held with start asserted: everything stays at zero.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("reset busy/done", {busy_a, done_a, busy_b, done_b}, 4'b0000);
            check("reset result/index", {result_a, index_a, result_b, index_b}, '0);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_job(1'b0, vecs[v].nums, vecs[v].mm, vecs[v].sg, vecs[v].exp_res, vecs[v].exp_idx,
                    $sformatf("vec%0d L1", v));
            run_job(1'b1, vecs[v].nums, vecs[v].mm, vecs[v].sg, vecs[v].exp_res, vecs[v].exp_idx,
                    $sformatf("vec%0d L3", v));
        end

        // Re-pulse start mid-scan with changed data: ignored, single done, original result.
        @(negedge clk);
        start_a = 1'b1; nums_a = DATA; mode_a = 1'b0; sgn_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        cnt = 0;
        first_k = 0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 3) begin start_a = 1'b1; nums_a = '0; mode_a = 1'b1; end
            if (k == 4) start_a = 1'b0;
            @(negedge clk);
            if (done_a) begin
                cnt++;
                if (first_k == 0) first_k = k;
            end
        end
        check("repulse done count", cnt, 1);
        check("repulse latency", first_k, 8);
        check("repulse result", {result_a, index_a}, {16'h0003, 3'd1});

        // Continuous start on the 3-lane instance: done every G+1 = 4 clocks.
        @(negedge clk);
        start_b = 1'b1; nums_b = DATA; mode_b = 1'b1; sgn_b = 1'b0;
        @(posedge clk);
        cnt = 0;
        prev_k = -1;
        gaps_ok = 1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (done_b) begin
                if (prev_k >= 0 && (k - prev_k) != 4) gaps_ok = 0;
                if (cnt == 0) first_k = k;
                prev_k = k;
                cnt++;
            end
        end
        start_b = 1'b0;
        check("streaming done count", cnt, 4);
        check("streaming first latency", first_k, 3);
        check("streaming period", gaps_ok, 1);
        check("streaming result", {result_b, index_b}, {16'hFFFF, 3'd2});

        // Reset mid-scan: outputs clear immediately, no done, next job is full latency.
        @(negedge clk);
        start_a = 1'b1; nums_a = DATA; mode_a = 1'b1; sgn_a = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midscan reset outputs", {busy_a, done_a, result_a, index_a}, '0);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done_a) cnt++;
        end
        check("midscan reset no done", cnt, 0);
        rst_n = 1'b1;
        run_job(1'b0, DATA, 1'b0, 1'b0, 16'h0003, 1, "after reset");

        // Randomized jobs against the model; every other job uses tiny values to force ties.
        for (int j = 0; j < 40; j++) begin
            for (int e = 0; e < N; e++)
                rn[e*W +: W] = (j % 2 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
            if (j % 4 == 1) rn[W*N-1 -: W] = 16'h8000 | W'($urandom_range(0, 1)) * 16'h7FFF;
            rm = 1'($urandom);
            rs = 1'($urandom);
            model(rn, rm, rs, r, ix);
            run_job(j[0], rn, rm, rs, r, ix, $sformatf("rand%0d", j));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
